// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : shared types and helpers for the SPI shift engine
// Revision: 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int SPI_MAX_LEN   = 32;
  localparam int SPI_DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } spi_state_e;

  // A length of zero, or one beyond the datapath width, means a full-width transfer.
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned max_len);
    return ((len == 0) || (len > max_len)) ? max_len : len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_shift_engine_if.sv
// ============================================================================
// spi_shift_engine_if : register-slave handshake and SPI pins of the engine
// Revision: 1.0
// ============================================================================
`default_nettype none

interface spi_shift_engine_if
  import spi_pkg::*;
#(
  parameter int MAX_LEN   = SPI_MAX_LEN,
  parameter int DIV_WIDTH = SPI_DIV_WIDTH
) ();

  localparam int LEN_W = $clog2(MAX_LEN) + 1;

  logic                 go_i;
  logic [LEN_W-1:0]     len_i;
  logic [DIV_WIDTH-1:0] div_i;
  logic                 cpol_i;
  logic                 cpha_i;
  logic                 lsb_i;
  logic [MAX_LEN-1:0]   tx_dat_i;
  logic [MAX_LEN-1:0]   rx_dat_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 sclk_o;
  logic                 mosi_o;
  logic                 miso_i;
  logic                 ss_n_o;

  modport master (
    output go_i, len_i, div_i, cpol_i, cpha_i, lsb_i, tx_dat_i, miso_i,
    input  rx_dat_o, busy_o, done_o, sclk_o, mosi_o, ss_n_o
  );

  modport slave (
    input  go_i, len_i, div_i, cpol_i, cpha_i, lsb_i, tx_dat_i, miso_i,
    output rx_dat_o, busy_o, done_o, sclk_o, mosi_o, ss_n_o
  );

endinterface

`default_nettype wire

// File: rtl/spi_clkgen.sv
// ============================================================================
// spi_clkgen : half-period down-counter, one-cycle tick when it reaches zero
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_clkgen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  localparam logic [DIV_WIDTH-1:0] c_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_tick) begin
      r_cnt <= i_div;
    end else if (i_en) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_shift_engine.sv
// ============================================================================
// spi_shift_engine : SPI serial back-end (SCLK/MOSI/SS_n generation, MISO capture)
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int MAX_LEN   = SPI_MAX_LEN,
  parameter int DIV_WIDTH = SPI_DIV_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_shift_engine_if.slave bus
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [LEN_W-1:0] c_ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_ZERO  = LEN_W'(0);
  localparam logic [LEN_W:0]   c_E_ONE = (LEN_W + 1)'(1);

  spi_state_e           r_state;
  logic [MAX_LEN-1:0]   r_tx;
  logic [MAX_LEN-1:0]   r_rx_sh;
  logic [MAX_LEN-1:0]   r_rx;
  logic [LEN_W-1:0]     r_len;
  logic [DIV_WIDTH-1:0] r_div;
  logic                 r_cpol;
  logic                 r_cpha;
  logic                 r_lsb;
  logic [LEN_W:0]       r_ecnt;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_sclk;
  logic                 r_mosi;
  logic                 r_ss_n;

  logic                 w_go;
  logic                 w_en;
  logic                 w_tick;
  logic [DIV_WIDTH-1:0] w_div;
  logic [LEN_W-1:0]     w_len_in;
  logic [LEN_W-1:0]     w_bidx;
  logic [LEN_W-1:0]     w_bidx1;
  logic [IDX_W-1:0]     w_pos_first;
  logic [IDX_W-1:0]     w_pos_cur;
  logic [IDX_W-1:0]     w_pos_nxt;
  logic                 w_lead;
  logic                 w_last_edge;
  logic                 w_sample;

  assign w_go     = (r_state == IDLE) && bus.go_i;
  assign w_en     = r_state inside {SETUP, SHIFT, HOLD};
  assign w_div    = w_go ? bus.div_i : r_div;
  assign w_len_in = LEN_W'(norm_len(32'(bus.len_i), MAX_LEN));

  // Edge counter: even values are leading SCLK edges, the upper bits the bit index.
  assign w_bidx      = r_ecnt[LEN_W:1];
  assign w_bidx1     = w_bidx + c_ONE;
  assign w_lead      = ~r_ecnt[0];
  assign w_last_edge = (r_ecnt == ({r_len, 1'b0} - c_E_ONE));
  assign w_sample    = w_lead ^ r_cpha;

  assign w_pos_first = IDX_W'(bus.lsb_i ? c_ZERO : (w_len_in - c_ONE));
  assign w_pos_cur   = IDX_W'(r_lsb ? w_bidx  : (r_len - w_bidx  - c_ONE));
  assign w_pos_nxt   = IDX_W'(r_lsb ? w_bidx1 : (r_len - w_bidx1 - c_ONE));

  spi_clkgen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_go),
    .i_en   (w_en),
    .i_div  (w_div),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tx    <= '0;
      r_rx_sh <= '0;
      r_rx    <= '0;
      r_len   <= '0;
      r_div   <= '0;
      r_cpol  <= 1'b0;
      r_cpha  <= 1'b0;
      r_lsb   <= 1'b0;
      r_ecnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_ss_n  <= 1'b1;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_sclk <= bus.cpol_i;
          r_mosi <= 1'b0;
          if (bus.go_i) begin
            r_tx    <= bus.tx_dat_i;
            r_len   <= w_len_in;
            r_div   <= bus.div_i;
            r_cpol  <= bus.cpol_i;
            r_cpha  <= bus.cpha_i;
            r_lsb   <= bus.lsb_i;
            r_rx_sh <= '0;
            r_ecnt  <= '0;
            r_busy  <= 1'b1;
            r_ss_n  <= 1'b0;
            r_mosi  <= bus.cpha_i ? 1'b0 : bus.tx_dat_i[w_pos_first];
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (w_tick) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            if (w_sample) begin
              r_rx_sh[w_pos_cur] <= bus.miso_i;
            end else if (r_cpha) begin
              r_mosi <= r_tx[w_pos_cur];
            end else if (!w_last_edge) begin
              r_mosi <= r_tx[w_pos_nxt];
            end
            if (w_last_edge) r_state <= HOLD;
            else             r_ecnt  <= r_ecnt + c_E_ONE;
          end
        end
        HOLD: begin
          if (w_tick) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_rx    <= r_rx_sh;
            r_ss_n  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_mosi  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rx_dat_o = r_rx;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;
  assign bus.sclk_o   = r_sclk;
  assign bus.mosi_o   = r_mosi;
  assign bus.ss_n_o   = r_ss_n;

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
// ============================================================================
// tb_spi_shift_engine : self-checking bench, per-cycle protocol model + directed cases
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_shift_engine;

  localparam int MAX_LEN   = 32;
  localparam int DIV_WIDTH = 16;
  localparam int LEN_W     = $clog2(MAX_LEN) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_shift_engine_if #(.MAX_LEN(MAX_LEN), .DIV_WIDTH(DIV_WIDTH)) bus ();

  spi_shift_engine #(.MAX_LEN(MAX_LEN), .DIV_WIDTH(DIV_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 0: loopback of MOSI, 1: tied high, 2: tied low
  int miso_mode = 0;
  assign bus.miso_i = (miso_mode == 0) ? bus.mosi_o : (miso_mode == 1);

  int          cyc = 0, checks = 0, errors = 0;
  bit          run_chk = 1'b0;
  int          m_t = 0, m_T = 0, m_len = 0, m_div = 0, m_miso = 0;
  logic        m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0, m_sclk_idle = 1'b0;
  logic [31:0] m_tx = '0, m_rx = '0;
  logic [4:0]  c_got, c_exp;
  int          c_h;

  // Transfer slot t = 1..T covers setup, 2*len SCLK half-periods and hold; slot T+1 is the done cycle.
  function automatic logic exp_bit(input int i);
    int p;
    p = m_lsb ? i : (m_len - 1 - i);
    return m_tx[p];
  endfunction

  function automatic logic exp_mosi(input int h);
    int idx;
    if (!m_cpha) idx = (h == 0) ? 0 : (h - 1) / 2;
    else begin
      if (h <= 1) return 1'b0;
      idx = (h - 2) / 2;
    end
    if (idx > m_len - 1) idx = m_len - 1;
    return exp_bit(idx);
  endfunction

  function automatic logic exp_sclk(input int h);
    if ((h == 0) || (h > 2 * m_len)) return m_cpol;
    return m_cpol ^ ((h % 2) == 0);
  endfunction

  function automatic logic [31:0] exp_rx();
    logic [63:0] mask;
    mask = (64'd1 << m_len) - 64'd1;
    if (m_miso == 0) return m_tx & mask[31:0];
    if (m_miso == 1) return mask[31:0];
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_t = 0; m_rx = '0; m_sclk_idle = 1'b0;
    end else if (m_t == 0) begin
      m_sclk_idle = bus.cpol_i;
      if (bus.go_i) begin
        m_tx   = bus.tx_dat_i;
        m_len  = ((bus.len_i == 0) || (int'(bus.len_i) > MAX_LEN)) ? MAX_LEN : int'(bus.len_i);
        m_div  = int'(bus.div_i);
        m_cpol = bus.cpol_i; m_cpha = bus.cpha_i; m_lsb = bus.lsb_i;
        m_miso = miso_mode;
        m_T    = (m_div + 1) * (2 * m_len + 2);
        m_t    = 1;
      end
    end else if (m_t == m_T + 1) begin
      m_t = 0; m_sclk_idle = m_cpol;
    end else begin
      m_t++;
      if (m_t == m_T + 1) m_rx = exp_rx();
    end
  end

  always @(negedge clk) begin
    if (run_chk) begin
      if (m_t == 0) c_exp = {2'b00, 1'b1, m_sclk_idle, 1'b0};
      else begin
        c_h = (m_t - 1) / (m_div + 1);
        if (m_t <= m_T) c_exp = {2'b10, 1'b0, exp_sclk(c_h), exp_mosi(c_h)};
        else            c_exp = {2'b11, 1'b1, m_cpol, exp_mosi(c_h)};
      end
      c_got = {bus.busy_o, bus.done_o, bus.ss_n_o, bus.sclk_o, bus.mosi_o};
      checks++;
      if ((c_got !== c_exp) || (bus.rx_dat_o !== m_rx)) begin
        errors++;
        $display("FAIL cycle %0d busy/done/ss_n/sclk/mosi got %b expected %b, rx got %h expected %h",
                 cyc, c_got, c_exp, bus.rx_dat_o, m_rx);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Returns k, the clock edge at which go is sampled.
  task automatic start(input logic cpol, input logic cpha, input logic lsb, input int len,
                       input int div, input logic [31:0] tx, input bit hold_go, output int k);
    @(negedge clk);
    bus.cpol_i   = cpol;
    bus.cpha_i   = cpha;
    bus.lsb_i    = lsb;
    bus.len_i    = LEN_W'(len);
    bus.div_i    = DIV_WIDTH'(div);
    bus.tx_dat_i = tx;
    bus.go_i     = 1'b1;
    @(negedge clk);
    k = cyc;
    if (!hold_go) bus.go_i = 1'b0;
  endtask

  // dcyc is the edge at which done_o is sampled high; pulses counts SCLK rising edges.
  task automatic wait_done(input int budget, output int dcyc, output int pulses);
    logic prev;
    prev   = bus.sclk_o;
    dcyc   = -1;
    pulses = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.sclk_o && !prev) pulses++;
      prev = bus.sclk_o;
      if (bus.done_o === 1'b1) begin
        dcyc = cyc + 1;
        break;
      end
    end
    if (dcyc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_o within %0d cycles", budget);
    end
  endtask

  task automatic count_done(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) cnt++;
    end
  endtask

  initial begin
    int k, d, d2, p, n;
    bus.go_i = 1'b0; bus.len_i = '0; bus.div_i = '0; bus.cpol_i = 1'b0;
    bus.cpha_i = 1'b0; bus.lsb_i = 1'b0; bus.tx_dat_i = '0;

    repeat (3) @(negedge clk);
    run_chk = 1'b1;
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_ss_n", bus.ss_n_o, 1);
    chk("rst_sclk", bus.sclk_o, 0);
    chk("rst_mosi", bus.mosi_o, 0);
    chk("rst_rx",   bus.rx_dat_o, 0);
    rst_n = 1'b1;

    // Mode 0, MSB first, 8 bits, fastest SCLK, loopback
    miso_mode = 0;
    start(1'b0, 1'b0, 1'b0, 8, 0, 32'hA5, 1'b0, k);
    wait_done(100, d, p);
    chk("t1_done_cyc", d, k + 19);
    chk("t1_pulses", p, 8);
    chk("t1_rx", bus.rx_dat_o, 32'hA5);

    // Mode 3, LSB first, 16 bits, div 3, MISO high
    miso_mode = 1;
    start(1'b1, 1'b1, 1'b1, 16, 3, 32'h1234, 1'b0, k);
    wait_done(300, d, p);
    chk("t2_done_cyc", d, k + 137);
    chk("t2_rx", bus.rx_dat_o, 32'hFFFF);
    repeat (3) @(negedge clk);
    chk("t2_sclk_idle", bus.sclk_o, 1);

    // Length 0 means full width
    miso_mode = 0;
    start(1'b0, 1'b0, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0, k);
    wait_done(200, d, p);
    chk("t3_len0_done_cyc", d, k + 67);
    chk("t3_len0_rx", bus.rx_dat_o, 32'hDEADBEEF);

    miso_mode = 1;
    start(1'b0, 1'b1, 1'b0, 5, 1, 32'h0, 1'b0, k);
    wait_done(100, d, p);
    chk("t3_len5_done_cyc", d, k + 25);
    chk("t3_len5_rx", bus.rx_dat_o, 32'h1F);

    miso_mode = 0;
    start(1'b1, 1'b0, 1'b1, 33, 0, 32'h80000001, 1'b0, k);
    wait_done(200, d, p);
    chk("t3_len33_done_cyc", d, k + 67);
    chk("t3_len33_rx", bus.rx_dat_o, 32'h80000001);

    // go and config churn while busy must be ignored
    start(1'b0, 1'b0, 1'b0, 8, 0, 32'h3C, 1'b0, k);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bus.go_i = ~bus.go_i;
      bus.tx_dat_i = 32'hFF;
      bus.len_i = LEN_W'(4);
    end
    bus.go_i = 1'b0;
    count_done(40, n);
    chk("t4_done_count", n, 1);
    chk("t4_rx", bus.rx_dat_o, 32'h3C);

    // Reset part-way through a transfer
    start(1'b0, 1'b0, 1'b0, 8, 0, 32'hA5, 1'b0, k);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_ss_n", bus.ss_n_o, 1);
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_sclk", bus.sclk_o, 0);
    chk("t5_rx", bus.rx_dat_o, 0);
    chk("t5_done", bus.done_o, 0);
    rst_n = 1'b1;
    count_done(25, n);
    chk("t5_no_done", n, 0);
    start(1'b0, 1'b0, 1'b0, 8, 0, 32'h5A, 1'b0, k);
    wait_done(100, d, p);
    chk("t5_retry_done_cyc", d, k + 19);
    chk("t5_retry_rx", bus.rx_dat_o, 32'h5A);

    // go held high: second transfer starts the cycle after DONE
    start(1'b0, 1'b0, 1'b0, 8, 0, 32'hC3, 1'b1, k);
    wait_done(100, d, p);
    wait_done(100, d2, p);
    bus.go_i = 1'b0;
    chk("t6_first_done_cyc", d, k + 19);
    chk("t6_second_done_cyc", d2, k + 39);
    count_done(30, n);
    chk("t6_extra_done", n, 0);
    chk("t6_rx", bus.rx_dat_o, 32'hC3);

    run_chk = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

`default_nettype wire
